// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared field layout, line geometry and FSM encoding for the D-cache refill controller.
package dcache_refill_ctrl_pkg;

  localparam int ADDR_W         = 8;
  localparam int WORD_W         = 8;
  localparam int TAG_W          = 2;
  localparam int IDX_W          = 4;
  localparam int OFF_W          = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;

  // Byte address is {tag, index, offset}
  localparam int OFF_LSB = 0;
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  k);
    return line[k*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// Cache-side miss/refill signals plus the single-beat req/ack memory port.
// master = refill controller, slave = cache and memory environment.
interface dcache_refill_ctrl_if;
  import dcache_refill_ctrl_pkg::*;

  logic                miss_req;
  logic [ADDR_W-1:0]   miss_addr;
  logic                victim_dirty;
  logic [TAG_W-1:0]    victim_tag;
  logic [LINE_W-1:0]   victim_data;
  logic                busy;
  logic                refill_done;
  logic [LINE_W-1:0]   refill_data;
  logic                crit_valid;
  logic [WORD_W-1:0]   crit_data;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [WORD_W-1:0]   mem_rdata;

  modport master (
    input  miss_req, miss_addr, victim_dirty, victim_tag, victim_data, mem_ack, mem_rdata,
    output busy, refill_done, refill_data, crit_valid, crit_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output miss_req, miss_addr, victim_dirty, victim_tag, victim_data, mem_ack, mem_rdata,
    input  busy, refill_done, refill_data, crit_valid, crit_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_buf.sv
// Four-word line register: parallel load or single indexed word write, parallel read.
// Latency: writes visible the cycle after the edge; read is combinational from state.
// Backpressure: none, accepts a load or write every cycle (load wins).
module dcache_line_buf
  import dcache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en_i,
  input  logic [LINE_W-1:0] ld_dat_i,
  input  logic              wr_en_i,
  input  logic [OFF_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_dat_i,
  output logic [LINE_W-1:0] rd_dat_o
);

  logic [WORD_W-1:0] word_q [WORDS_PER_LINE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) word_q[k] <= '0;
    end else if (ld_en_i) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) word_q[k] <= ld_dat_i[k*WORD_W +: WORD_W];
    end else if (wr_en_i) begin
      word_q[wr_idx_i] <= wr_dat_i;
    end
  end

  always_comb begin
    rd_dat_o = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) rd_dat_o[k*WORD_W +: WORD_W] = word_q[k];
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// D-cache miss handler: dirty-victim writeback then line refill; DCACHE_CRIT_WORD_FIRST_EN enables critical-word-first fill.
// Latency: refill_done 1 + 4 (+4 if dirty) + 1 cycles from acceptance, plus one per memory wait state.
// Backpressure: each beat holds request outputs until mem_ack; miss_req sampled only when idle.
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  dcache_refill_ctrl_if.master bus
);

  state_e             state_q;
  logic [OFF_W-1:0]   beat_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [WORD_W-1:0]  mem_wdata_q;

  logic [LINE_W-1:0]  victim_line;
  logic [LINE_W-1:0]  refill_line;
  logic [OFF_W-1:0]   start_d;
  logic [OFF_W-1:0]   fill_start;
  logic [OFF_W-1:0]   beat_nxt;
  logic [TAG_W-1:0]   miss_tag;
  logic [IDX_W-1:0]   miss_idx;
  logic               accept;
  logic               beat_fire;
  logic               fill_wr;

  assign miss_tag  = bus.miss_addr[TAG_LSB +: TAG_W];
  assign miss_idx  = bus.miss_addr[IDX_LSB +: IDX_W];
  assign accept    = (state_q == IDLE) && bus.miss_req;
  assign beat_fire = mem_req_q && bus.mem_ack;
  assign fill_wr   = (state_q == FILL) && beat_fire;
  assign beat_nxt  = beat_q + 1'b1;

`ifdef DCACHE_CRIT_WORD_FIRST_EN
  logic [OFF_W-1:0]  off_q;
  logic              crit_valid_q;
  logic [WORD_W-1:0] crit_data_q;

  assign start_d    = bus.miss_addr[OFF_LSB +: OFF_W];
  assign fill_start = off_q;

  // The first read beat of a fill is the one whose index equals the start offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q        <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      if (accept) off_q <= start_d;
      if (fill_wr && (beat_q == fill_start)) begin
        crit_valid_q <= 1'b1;
        crit_data_q  <= bus.mem_rdata;
      end
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  logic unused_off;

  assign unused_off     = ^bus.miss_addr[OFF_LSB +: OFF_W];
  assign start_d        = '0;
  assign fill_start     = '0;
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

  dcache_line_buf u_victim_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_en_i  (accept),
    .ld_dat_i (bus.victim_data),
    .wr_en_i  (1'b0),
    .wr_idx_i ('0),
    .wr_dat_i ('0),
    .rd_dat_o (victim_line)
  );

  dcache_line_buf u_refill_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_en_i  (1'b0),
    .ld_dat_i ('0),
    .wr_en_i  (fill_wr),
    .wr_idx_i (beat_q),
    .wr_dat_i (bus.mem_rdata),
    .rd_dat_o (refill_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      tag_q       <= '0;
      vtag_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_req) begin
            tag_q     <= miss_tag;
            idx_q     <= miss_idx;
            vtag_q    <= bus.victim_tag;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            if (bus.victim_dirty) begin
              state_q     <= WB;
              beat_q      <= '0;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {bus.victim_tag, miss_idx, {OFF_W{1'b0}}};
              mem_wdata_q <= line_word(bus.victim_data, '0);
            end else begin
              state_q     <= FILL;
              beat_q      <= start_d;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {miss_tag, miss_idx, start_d};
              mem_wdata_q <= '0;
            end
          end
        end
        WB: begin
          if (beat_fire) begin
            if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
              state_q     <= FILL;
              beat_q      <= fill_start;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {tag_q, idx_q, fill_start};
              mem_wdata_q <= '0;
            end else begin
              beat_q      <= beat_nxt;
              mem_addr_q  <= {vtag_q, idx_q, beat_nxt};
              mem_wdata_q <= line_word(victim_line, beat_nxt);
            end
          end
        end
        FILL: begin
          // Counter wraps mod 4, so the fill is complete once it would return to its start.
          if (beat_fire) begin
            if (beat_nxt == fill_start) begin
              state_q    <= RESP;
              beat_q     <= '0;
              mem_req_q  <= 1'b0;
              mem_addr_q <= '0;
              done_q     <= 1'b1;
            end else begin
              beat_q     <= beat_nxt;
              mem_addr_q <= {tag_q, idx_q, beat_nxt};
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.refill_done = done_q;
  assign bus.refill_data = done_q ? refill_line : '0;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed + randomized bench for dcache_refill_ctrl against a memory/line-level reference model.
`timescale 1ns/1ps
module tb_dcache_refill_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_refill_ctrl_if bus ();

  dcache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } beat_t;

  beat_t      beats[$];
  beat_t      prev_beat;
  logic [7:0] mem_model [256];
  int         vectors     = 0;
  int         miscompares = 0;
  int         wait_cfg    = 0;
  int         wait_cnt    = 0;
  logic       ack_spur    = 1'b0;
  logic       fire_seen   = 1'b0;
  logic       req_seen    = 1'b0;
  logic       prev_wait   = 1'b0;
  int         done_cnt    = 0;
  int         crit_cnt    = 0;
  int         crit_pos    = 0;
  logic [7:0] crit_last   = 8'h00;

  // Memory: acks after wait_cfg stall cycles; acks with no request are noise the DUT must ignore.
  assign bus.mem_ack   = bus.mem_req ? (wait_cnt >= wait_cfg) : ack_spur;
  assign bus.mem_rdata = mem_model[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int n_reads();
    int n = 0;
    foreach (beats[i]) if (!beats[i].we) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
      fire_seen = 1'b0;
      req_seen  = 1'b0;
    end else begin
      if (bus.mem_req && prev_wait) begin
        chk("hold_we", bus.mem_we, prev_beat.we);
        chk("hold_addr", bus.mem_addr, prev_beat.addr);
        chk("hold_wdata", bus.mem_wdata, prev_beat.wdata);
      end
      if (bus.crit_valid) begin
        crit_cnt++;
        crit_last = bus.crit_data;
        crit_pos  = n_reads();
      end
      if (bus.refill_done) done_cnt++;
      req_seen  = bus.mem_req;
      fire_seen = bus.mem_req && bus.mem_ack;
      prev_wait = bus.mem_req && !bus.mem_ack;
      prev_beat = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (fire_seen) begin
        beats.push_back(prev_beat);
        if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
      end
    end
  end

  always @(posedge clk) begin
    ack_spur <= 1'($urandom);
    if (fire_seen || !req_seen) wait_cnt <= 0;
    else                        wait_cnt <= wait_cnt + 1;
  end

  // One complete miss, called and returning at a falling edge with the DUT idle.
  task automatic do_miss(input logic [7:0] addr, input logic dirty, input logic [1:0] vtag,
                         input logic [31:0] vdata, input int waits);
    beat_t       exp_q[$];
    logic [31:0] exp_line;
    logic [1:0]  start;
    logic [1:0]  o;
    logic [7:0]  a;
    logic        got;
    int          cyc, nbeats, d0, c0;
`ifdef DCACHE_CRIT_WORD_FIRST_EN
    start = addr[1:0];
`else
    start = 2'd0;
`endif
    exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      a = {vtag, addr[5:2], 2'(k)};
      if (dirty) exp_q.push_back('{1'b1, a, vdata[8*k +: 8]});
    end
    for (int k = 0; k < 4; k++) begin
      a = {addr[7:2], 2'(k)};
      exp_line[8*k +: 8] = (dirty && vtag == addr[7:6]) ? vdata[8*k +: 8] : mem_model[a];
    end
    for (int k = 0; k < 4; k++) begin
      o = start + 2'(k);
      exp_q.push_back('{1'b0, {addr[7:2], o}, 8'h00});
    end
    nbeats   = dirty ? 8 : 4;
    wait_cfg = waits;
    beats.delete();
    d0 = done_cnt;
    c0 = crit_cnt;

    bus.miss_req     = 1'b1;
    bus.miss_addr    = addr;
    bus.victim_dirty = dirty;
    bus.victim_tag   = vtag;
    bus.victim_data  = vdata;
    @(posedge clk);
    #1;
    bus.miss_addr    = 8'($urandom);
    bus.victim_tag   = 2'($urandom);
    bus.victim_data  = $urandom;
    bus.victim_dirty = 1'($urandom);

    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("busy_on", bus.busy, 1);
      got = bus.refill_done;
    end
    chk("done_seen", got, 1);
    chk("done_cycle", cyc, 2 + nbeats * (1 + waits));
    chk("refill_data", bus.refill_data, exp_line);
    bus.miss_req = 1'b0;
    @(negedge clk);
    #1;
    chk("done_pulse", bus.refill_done, 0);
    chk("busy_off", bus.busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("beat_count", beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      chk("beat_we", beats[i].we, exp_q[i].we);
      chk("beat_addr", beats[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk("beat_wdata", beats[i].wdata, exp_q[i].wdata);
    end
`ifdef DCACHE_CRIT_WORD_FIRST_EN
    chk("crit_count", crit_cnt - c0, 1);
    chk("crit_data", crit_last, exp_line[8*start +: 8]);
    chk("crit_pos", crit_pos, 1);
`else
    chk("crit_count", crit_cnt - c0, 0);
    chk("crit_data", bus.crit_data, 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    int         cyc;
    int         d0;
    logic [7:0] ra;

    rst_n            = 1'b0;
    bus.miss_req     = 1'b0;
    bus.miss_addr    = '0;
    bus.victim_dirty = 1'b0;
    bus.victim_tag   = '0;
    bus.victim_data  = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
    mem_model[8'h58] = 8'h11;
    mem_model[8'h59] = 8'h22;
    mem_model[8'h5A] = 8'h33;
    mem_model[8'h5B] = 8'h44;

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.refill_done, 0);
    chk("rst_rdata", bus.refill_data, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_crit_v", bus.crit_valid, 0);
    chk("rst_crit_d", bus.crit_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean miss, then dirty miss, then clean miss with two wait states per beat
    do_miss(8'h5A, 1'b0, 2'b10, 32'h0BADF00D, 0);
    chk("clean_line", {mem_model[8'h5B], mem_model[8'h5A], mem_model[8'h59], mem_model[8'h58]}, 32'h44332211);
    do_miss(8'h24, 1'b1, 2'b11, 32'hDDCCBBAA, 0);
    chk("wb_mem", {mem_model[8'hE7], mem_model[8'hE6], mem_model[8'hE5], mem_model[8'hE4]}, 32'hDDCCBBAA);
    do_miss(8'h5A, 1'b0, 2'b00, 32'h0, 2);

    // Reset after the second writeback beat completes
    wait_cfg = 0;
    beats.delete();
    d0 = done_cnt;
    bus.miss_req     = 1'b1;
    bus.miss_addr    = 8'h9C;
    bus.victim_dirty = 1'b1;
    bus.victim_tag   = 2'b01;
    bus.victim_data  = $urandom;
    cyc = 0;
    while (beats.size() < 2 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("rst_reach_beat1", beats.size(), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.refill_done, 0);
    bus.miss_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_refill", done_cnt - d0, 0);
    chk("abort_no_more_beats", beats.size(), 2);
    rst_n = 1'b1;
    @(negedge clk);
    do_miss(8'h9C, 1'b0, 2'b01, 32'h0, 0);

    // Request held through RESP yields one refill; a fresh assertion is then accepted
    do_miss(8'h31, 1'b0, 2'b00, 32'h0, 1);
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("b2b_idle", bus.busy, 0);
    chk("b2b_single", done_cnt - d0, 0);
    do_miss(8'h31, 1'b1, 2'b10, $urandom, 0);

    for (int n = 0; n < 16; n++) begin
      ra = 8'($urandom);
      do_miss(ra, 1'($urandom), 2'($urandom), $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
